// File: rtl/burst_ram_initiator.sv
// burst_ram_initiator: turns one line request (BURST_COUNT x 64-bit beats)
// into a single RAM burst command and gathers/streams the beats.
// Optional build macro: BURST_TIMEOUT_EN adds a read watchdog that ends a
// stalled read collection after TIMEOUT_CYCLES beat-less cycles with
// resp_error=1.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE, out of reset, with
// the RAM not busy. The requester holds its request stable while req_valid is
// high and req_ready is low. resp_valid is a one-cycle completion pulse with
// no back-pressure; resp_error and resp_rdata are qualified by it.
module burst_ram_initiator #(
    parameter int BURST_COUNT    = 4,
    parameter int DEPTH_BITWIDTH = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [DEPTH_BITWIDTH-1:0]   req_addr,
    input  logic [64*BURST_COUNT-1:0]   req_wdata,
    input  logic [8*BURST_COUNT-1:0]    req_wben,
    output logic                        resp_valid,
    output logic [64*BURST_COUNT-1:0]   resp_rdata,
    output logic                        resp_error,
    output logic                        cmd,
    output logic                        cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]   addr,
    output logic [63:0]                 wr_data,
    output logic [7:0]                  data_mask,
    input  logic [63:0]                 rd_data,
    input  logic                        rd_data_valid,
    input  logic                        busy,
    output logic [2:0]                  dbg_state
);

    localparam int BEAT_W = $clog2(BURST_COUNT);
    localparam int LINE_W = 64 * BURST_COUNT;
    localparam int BE_W   = 8 * BURST_COUNT;
    localparam logic [BEAT_W-1:0]         LAST_BEAT  = BEAT_W'(BURST_COUNT - 1);
    localparam logic [DEPTH_BITWIDTH-1:0] ALIGN_MASK = ~(DEPTH_BITWIDTH'(BURST_COUNT - 1));

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_RD_CMD     = 3'd1;
    localparam logic [2:0] S_RD_COLLECT = 3'd2;
    localparam logic [2:0] S_WR_BURST   = 3'd3;
    localparam logic [2:0] S_RESP       = 3'd4;

    // Reject parameter sets the beat/alignment logic cannot handle.
    if (BURST_COUNT < 2 || (BURST_COUNT & (BURST_COUNT - 1)) != 0 ||
        TIMEOUT_CYCLES < 1 || DEPTH_BITWIDTH < $clog2(BURST_COUNT)) begin : g_param_check
        $error("burst_ram_initiator: unsupported parameter set");
    end

    logic [2:0]        r_state;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic [LINE_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_wben;
    logic [LINE_W-1:0] r_rbuf;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic [LINE_W-1:0] w_rbuf_nxt;
    logic              w_accept;

`ifdef BURST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_to_cnt;
`endif

    // Ready depends on live busy so a busy RAM can never be handed a request.
    assign req_ready  = rst && (r_state == S_IDLE) && !busy;
    assign w_accept   = req_valid && req_ready;
    assign w_beat_nxt = r_beat_cnt + 1'b1;
    assign dbg_state  = r_state;

    // Read line buffer with the incoming beat merged into its slot.
    always_comb begin
        w_rbuf_nxt = r_rbuf;
        w_rbuf_nxt[int'(r_beat_cnt)*64 +: 64] = rd_data;
    end

    // Transfer FSM; every RAM-side and response output is a register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_wdata    <= '0;
            r_wben     <= '0;
            r_rbuf     <= '0;
            cmd        <= 1'b0;
            cmd_en     <= 1'b0;
            addr       <= '0;
            wr_data    <= '0;
            data_mask  <= '0;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= '0;
`ifdef BURST_TIMEOUT_EN
            r_to_cnt   <= '0;
`endif
        end else begin
            // Command strobes and write lanes idle unless a state drives them.
            cmd_en     <= 1'b0;
            wr_data    <= '0;
            data_mask  <= '0;
            resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        addr       <= req_addr & ALIGN_MASK;
                        r_wdata    <= req_wdata;
                        r_wben     <= req_wben;
                        r_beat_cnt <= '0;
                        cmd_en     <= 1'b1;
                        if (req_write) begin
                            r_state   <= S_WR_BURST;
                            cmd       <= 1'b1;
                            wr_data   <= req_wdata[63:0];
                            data_mask <= ~req_wben[7:0];
                        end else begin
                            r_state <= S_RD_CMD;
                            cmd     <= 1'b0;
                        end
                    end
                end
                S_RD_CMD: begin
                    r_state    <= S_RD_COLLECT;
                    r_beat_cnt <= '0;
`ifdef BURST_TIMEOUT_EN
                    r_to_cnt   <= '0;
`endif
                end
                S_RD_COLLECT: begin
                    if (rd_data_valid) begin
                        r_rbuf     <= w_rbuf_nxt;
                        r_beat_cnt <= w_beat_nxt;
`ifdef BURST_TIMEOUT_EN
                        r_to_cnt   <= '0;
`endif
                        if (r_beat_cnt == LAST_BEAT) begin
                            resp_rdata <= w_rbuf_nxt;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b0;
                            r_state    <= S_RESP;
                        end
                    end
`ifdef BURST_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        // Stalled RAM: give up, keep the previous read line.
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        r_beat_cnt <= '0;
                        r_state    <= S_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                S_WR_BURST: begin
                    r_beat_cnt <= w_beat_nxt;
                    if (r_beat_cnt == LAST_BEAT) begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        r_state    <= S_RESP;
                    end else begin
                        wr_data   <= r_wdata[int'(w_beat_nxt)*64 +: 64];
                        data_mask <= ~r_wben[int'(w_beat_nxt)*8 +: 8];
                    end
                end
                S_RESP: begin
                    resp_error <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_ram_initiator.sv
// Self-checking bench for burst_ram_initiator with a 4-cycle-latency RAM model.
// Build with BURST_TIMEOUT_EN defined to exercise the read watchdog.
module tb_burst_ram_initiator;

    localparam int BC = 4;
    localparam int DW = 4;
    localparam int TO = 16;
    localparam int LW = 64 * BC;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [DW-1:0]   req_addr = '0;
    logic [LW-1:0]   req_wdata = '0;
    logic [8*BC-1:0] req_wben = '0;
    logic            resp_valid;
    logic [LW-1:0]   resp_rdata;
    logic            resp_error;
    logic            cmd;
    logic            cmd_en;
    logic [DW-1:0]   addr;
    logic [63:0]     wr_data;
    logic [7:0]      data_mask;
    logic [63:0]     rd_data;
    logic            rd_data_valid;
    logic            busy = 1'b0;
    logic [2:0]      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [LW-1:0] exp_q[$];
    logic [LW-1:0] last_rdata = '0;
    logic [63:0]   gold[16];

    // RAM model state
    logic [63:0] ram_mem[16];
    bit          load_mem = 1'b0;
    bit          gap_en = 1'b0;
    bit          ram_mute = 1'b0;
    bit          rd_pend = 1'b0;
    int          rd_wait = 0;
    int          rd_beat = 0;
    int          gap_left = 0;
    logic [3:0]  rd_a = '0;
    bit          wr_pend = 1'b0;
    int          wr_i = 0;
    logic [3:0]  wr_a = '0;

    burst_ram_initiator #(
        .BURST_COUNT(BC), .DEPTH_BITWIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wben(req_wben), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
        .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int i);
        case (i)
            0: return 64'h3F5A2E14B7C6A980;
            1: return 64'h9D8E2F17AB4C3E6F;
            2: return 64'hA1C3F7E2D5B8A9C4;
            3: return 64'h7D4E9F2C1B6A3D8F;
            4: return 64'h6C4B9A8D2F5E3C7A;
            5: return 64'hE1A7D0B5C8F3E6A9;
            6: return 64'hF8E9D2C3B4A5F6E7;
            7: return 64'hD4E7F2C5B8A3D6E9;
            default: return {32'hCAFE0000 | 32'(i), 32'h5A5A0000 | 32'(i)};
        endcase
    endfunction

    // keep bit 1 = keep the old byte
    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] keep);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = keep[b] ? old_w[b*8 +: 8] : new_w[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [LW-1:0] gold_line(input logic [3:0] a);
        logic [LW-1:0] l;
        for (int i = 0; i < BC; i++) l[i*64 +: 64] = gold[{a[3:2], 2'(i)}];
        return l;
    endfunction

    // RAM model: read beats start 4 cycles after the command; writes take
    // beat 0 with the command and the rest on the following edges.
    always @(posedge clk) begin
        rd_data_valid <= 1'b0;
        if (load_mem) begin
            for (int i = 0; i < 16; i++) ram_mem[i] <= init_word(i);
        end
        if (rd_pend) begin
            if (rd_wait > 0) begin
                rd_wait <= rd_wait - 1;
            end else if (gap_en && rd_beat == 2 && gap_left > 0) begin
                gap_left <= gap_left - 1;
            end else begin
                rd_data_valid <= 1'b1;
                rd_data       <= ram_mem[rd_a + 4'(rd_beat)];
                rd_beat       <= rd_beat + 1;
                if (rd_beat == 3) rd_pend <= 1'b0;
            end
        end
        if (cmd_en && !cmd && !ram_mute) begin
            rd_pend  <= 1'b1;
            rd_wait  <= 3;
            rd_a     <= addr;
            rd_beat  <= 0;
            gap_left <= 3;
        end
        if (wr_pend) begin
            ram_mem[wr_a + 4'(wr_i)] <= merge(ram_mem[wr_a + 4'(wr_i)], wr_data, data_mask);
            wr_i <= wr_i + 1;
            if (wr_i == 3) wr_pend <= 1'b0;
        end
        if (cmd_en && cmd) begin
            ram_mem[addr] <= merge(ram_mem[addr], wr_data, data_mask);
            wr_pend <= 1'b1;
            wr_i    <= 1;
            wr_a    <= addr;
        end
    end

    // Driver: present a request and hold it until accepted. Returns at the
    // falling edge of the first cycle after acceptance.
    task automatic issue(input bit wr, input logic [3:0] a, input logic [LW-1:0] wd,
                         input logic [31:0] be, output bit ok);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_wben = be;
        #1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk); n++;
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; ok = 1'b0; req_valid = 1'b0;
            $display("FAIL accept: req_ready=%b required 1 within 50 cycles", req_ready);
        end else begin
            @(negedge clk);
            req_valid = 1'b0; ok = 1'b1;
        end
    endtask

    // Driver: wait for resp_valid, counting beats and command pulses seen.
    task automatic wait_resp(input int max, output bit got, output int cyc, output int beats,
                             output bit prev_valid, output int pulses);
        bit pv;
        pv = 1'b0; got = 1'b0; beats = 0; pulses = 0; prev_valid = 1'b0; cyc = 0;
        while (cyc < max) begin
            if (resp_valid === 1'b1) begin
                got = 1'b1; prev_valid = pv; break;
            end
            pv = rd_data_valid;
            if (rd_data_valid === 1'b1) beats++;
            if (cmd_en === 1'b1) pulses++;
            @(negedge clk); cyc++;
        end
    endtask

    task automatic gold_write(input logic [3:0] a, input logic [LW-1:0] wd, input logic [31:0] be);
        for (int i = 0; i < BC; i++)
            gold[{a[3:2], 2'(i)}] = merge(gold[{a[3:2], 2'(i)}], wd[i*64 +: 64], ~be[i*8 +: 8]);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b0 || cmd_en !== 1'b0 || cmd !== 1'b0 || addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cmd: ready=%b cmd_en=%b cmd=%b addr=%h required 0/0/0/0",
                     req_ready, cmd_en, cmd, addr);
        end
        n_tests++;
        if (wr_data !== 64'd0 || data_mask !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_wr: wr_data=%h mask=%h required 0/0", wr_data, data_mask);
        end
        n_tests++;
        if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: valid=%b err=%b rdata=%h required 0/0/0",
                     resp_valid, resp_error, resp_rdata);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: req_ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_read_line(input logic [3:0] a, input bit gap, input string name);
        bit ok, got, pv;
        int cyc, beats, pulses;
        logic [LW-1:0] e;
        gap_en = gap;
        issue(1'b0, a, '0, '0, ok);
        if (!ok) begin gap_en = 1'b0; return; end
        exp_q.push_back(gold_line(a));
        n_tests++;
        if (cmd_en !== 1'b1 || cmd !== 1'b0 || addr !== (a & 4'hC)) begin
            n_fail++;
            $display("FAIL %s_cmd: cmd_en=%b cmd=%b addr=%h required 1/0/%h",
                     name, cmd_en, cmd, addr, a & 4'hC);
        end
        wait_resp(100, got, cyc, beats, pv, pulses);
        gap_en = 1'b0;
        e = exp_q.pop_front();
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s_timeout: resp_valid=0 after %0d cycles required a response", name, cyc);
            return;
        end
        n_tests++;
        if (beats !== 4 || pv !== 1'b1 || pulses !== 1) begin
            n_fail++;
            $display("FAIL %s_timing: beats=%0d prev_beat=%b cmd_pulses=%0d required 4/1/1",
                     name, beats, pv, pulses);
        end
        n_tests++;
        if (resp_rdata !== e || resp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_data: rdata=%h err=%b required %h/0", name, resp_rdata, resp_error, e);
        end
        last_rdata = e;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_pulse: resp_valid=%b req_ready=%b required 0/1",
                     name, resp_valid, req_ready);
        end
    endtask

    task automatic test_write(input logic [3:0] a, input logic [LW-1:0] wd,
                              input logic [31:0] be, input string name);
        bit ok;
        logic [7:0] em;
        issue(1'b1, a, wd, be, ok);
        if (!ok) return;
        gold_write(a, wd, be);
        for (int i = 0; i < BC; i++) begin
            em = ~be[i*8 +: 8];
            n_tests++;
            if (cmd_en !== (i == 0) || cmd !== 1'b1 || addr !== (a & 4'hC) ||
                wr_data !== wd[i*64 +: 64] || data_mask !== em) begin
                n_fail++;
                $display("FAIL %s_beat%0d: cmd_en=%b cmd=%b addr=%h data=%h mask=%h required %b/1/%h/%h/%h",
                         name, i, cmd_en, cmd, addr, wr_data, data_mask, (i == 0), a & 4'hC,
                         wd[i*64 +: 64], em);
            end
            @(negedge clk);
        end
        n_tests++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b0 || cmd_en !== 1'b0 ||
            wr_data !== 64'd0 || data_mask !== 8'd0 || resp_rdata !== last_rdata) begin
            n_fail++;
            $display("FAIL %s_resp: valid=%b err=%b cmd_en=%b data=%h mask=%h rdata=%h required 1/0/0/0/0/%h",
                     name, resp_valid, resp_error, cmd_en, wr_data, data_mask, resp_rdata, last_rdata);
        end
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse: resp_valid=%b required 0", name, resp_valid);
        end
    endtask

    task automatic test_spec_write();
        logic [LW-1:0] wd;
        wd = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        test_write(4'd8, wd, 32'hFF0FFFFF, "write8");
        test_read_line(4'd8, 1'b1, "readback8");
        n_tests++;
        if (resp_rdata[191:128] !== 64'hCAFE000A_33333333) begin
            n_fail++;
            $display("FAIL readback8_beat2: got %h required CAFE000A33333333", resp_rdata[191:128]);
        end
    endtask

    task automatic test_busy();
        bit got, pv;
        int cyc, beats, pulses;
        logic [LW-1:0] e;
        @(negedge clk);
        busy = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd1;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_tests++;
            if (req_ready !== 1'b0 || cmd_en !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_hold%0d: req_ready=%b cmd_en=%b required 0/0", i, req_ready, cmd_en);
            end
            @(negedge clk);
        end
        busy = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_release: req_ready=%b required 1", req_ready);
        end
        exp_q.push_back(gold_line(4'd0));
        @(negedge clk);
        req_valid = 1'b0;
        n_tests++;
        if (cmd_en !== 1'b1 || addr !== 4'd0) begin
            n_fail++;
            $display("FAIL busy_cmd: cmd_en=%b addr=%h required 1/0", cmd_en, addr);
        end
        busy = 1'b1;
        wait_resp(100, got, cyc, beats, pv, pulses);
        busy = 1'b0;
        e = exp_q.pop_front();
        n_tests++;
        if (!got || resp_rdata !== e) begin
            n_fail++;
            $display("FAIL busy_midxfer: got=%b rdata=%h required 1/%h", got, resp_rdata, e);
        end
        if (got) last_rdata = e;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n, seen;
        issue(1'b0, 4'd4, '0, '0, ok);
        if (!ok) return;
        n = 0; seen = 0;
        while (seen < 2 && n < 50) begin
            if (rd_data_valid === 1'b1) seen++;
            @(negedge clk); n++;
        end
        n_tests++;
        if (seen < 2) begin
            n_fail++;
            $display("FAIL rstmid_beats: saw %0d beats required 2", seen);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 1'b0 || cmd_en !== 1'b0 || resp_rdata !== '0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_values: valid=%b cmd_en=%b rdata=%h ready=%b required 0/0/0/0",
                     resp_valid, cmd_en, resp_rdata, req_ready);
        end
        rst = 1'b1;
        last_rdata = '0;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (resp_valid !== 1'b0 || resp_rdata !== '0) begin
                n_fail++;
                $display("FAIL rstmid_late%0d: valid=%b rdata=%h required 0/0", i, resp_valid, resp_rdata);
            end
            @(negedge clk);
        end
        test_read_line(4'd4, 1'b0, "rstmid_next");
    endtask

    task automatic test_timeout();
        bit ok, got, pv;
        int cyc, beats, pulses;
        ram_mute = 1'b1;
        issue(1'b0, 4'd0, '0, '0, ok);
        if (!ok) begin ram_mute = 1'b0; return; end
`ifdef BURST_TIMEOUT_EN
        wait_resp(100, got, cyc, beats, pv, pulses);
        ram_mute = 1'b0;
        n_tests++;
        if (!got || cyc !== TO + 1) begin
            n_fail++;
            $display("FAIL timeout_cycle: got=%b cycles=%0d required 1/%0d", got, cyc, TO + 1);
        end
        n_tests++;
        if (resp_error !== 1'b1 || resp_rdata !== last_rdata) begin
            n_fail++;
            $display("FAIL timeout_resp: err=%b rdata=%h required 1/%h", resp_error, resp_rdata, last_rdata);
        end
        @(negedge clk);
`else
        wait_resp(60, got, cyc, beats, pv, pulses);
        ram_mute = 1'b0;
        n_tests++;
        if (got || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL nowatchdog_wait: got=%b req_ready=%b required 0/0", got, req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_rdata = '0;
`endif
        test_read_line(4'd2, 1'b0, "after_stall");
    endtask

    task automatic test_random_traffic();
        logic [LW-1:0] wd;
        logic [3:0] a;
        for (int k = 0; k < 12; k++) begin
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < LW / 32; i++) wd[i*32 +: 32] = $urandom;
                test_write(a, wd, $urandom, "rnd_write");
            end else begin
                test_read_line(a, ($urandom_range(0, 3) == 0), "rnd_read");
            end
        end
    endtask

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) gold[i] = init_word(i);
        load_mem = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        load_mem = 1'b0;
        test_reset();
        test_read_line(4'd0, 1'b0, "read0");
        test_read_line(4'd4, 1'b0, "read4");
        test_read_line(4'd6, 1'b1, "read6_gap");
        test_spec_write();
        test_busy();
        test_reset_mid();
        test_timeout();
        test_random_traffic();
        repeat (8) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
